// File: rtl/seg7_pkg.sv
// Shared definitions for the Segment7 display path: BCD digit constants,
// direction encoding and a nibble validity helper.
package seg7_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    localparam logic UP   = 1'b0;
    localparam logic DOWN = 1'b1;

    function automatic logic is_bcd(input logic [BCD_W-1:0] nib);
        return (nib <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the BCD up/down counter: load, step with carry/borrow
// out, and a limit indication for the current direction.
module bcd_digit
    import seg7_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_in,
    input  logic             dir,
    input  logic             load,
    input  logic [BCD_W-1:0] load_nib,
    input  logic             wrap_en,
    output logic [BCD_W-1:0] digit,
    output logic             carry_out,
    output logic             at_limit
);

    assign at_limit  = (dir == UP) ? (digit == BCD_MAX) : (digit == '0);
    assign carry_out = step_in & at_limit;

    // wrap_en low freezes every digit so the whole counter saturates together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (load) begin
            digit <= is_bcd(load_nib) ? load_nib : '0;
        end else if (step_in && wrap_en) begin
            if (at_limit)
                digit <= (dir == UP) ? '0 : BCD_MAX;
            else if (dir == UP)
                digit <= digit + 4'd1;
            else
                digit <= digit - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with prescaled enable, parallel load,
// wrap/saturate limits and a terminal-count pulse.
module bcd_updown_counter
    import seg7_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int DIV    = 1,
    parameter int WRAP   = 1
) (
    input  logic                  CE,
    input  logic                  RESET,
    input  logic                  EN,
    input  logic                  REVERSE,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   LOAD_VAL,
    output logic [4*DIGITS-1:0]   CNT,
    output logic                  TC,
    output logic                  LOAD_ERR
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0]     pre;
    logic              tick;
    logic [DIGITS-1:0] carries;
    logic [DIGITS-1:0] limits;
    logic              all_at_limit;
    logic              wrap_en;
    logic              load_bad;

    assign tick         = EN & ~LOAD & (pre == PRE_LAST);
    assign all_at_limit = &limits;
    assign wrap_en      = (WRAP != 0) | ~all_at_limit;

    always_ff @(posedge CE or negedge RESET) begin
        if (!RESET)
            pre <= '0;
        else if (LOAD)
            pre <= '0;
        else if (EN)
            pre <= tick ? '0 : pre + PW'(1);
    end

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_digit
            bcd_digit u_digit (
                .clk      (CE),
                .rst_n    (RESET),
                .step_in  ((i == 0) ? tick : carries[(i == 0) ? 0 : i-1]),
                .dir      (REVERSE),
                .load     (LOAD),
                .load_nib (LOAD_VAL[4*i +: 4]),
                .wrap_en  (wrap_en),
                .digit    (CNT[4*i +: 4]),
                .carry_out(carries[i]),
                .at_limit (limits[i])
            );
        end
    endgenerate

    always_comb begin
        load_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++)
            load_bad = load_bad | ~is_bcd(LOAD_VAL[4*k +: 4]);
    end

    // the top digit's carry is exactly a tick taken with every digit at its limit
    always_ff @(posedge CE or negedge RESET) begin
        if (!RESET) begin
            TC       <= 1'b0;
            LOAD_ERR <= 1'b0;
        end else if (LOAD) begin
            TC       <= 1'b0;
            LOAD_ERR <= load_bad;
        end else begin
            TC       <= carries[DIGITS-1];
        end
    end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit BCD up/down counter for the Segment7 display path. It generalises the fixed three-digit counter to DIGITS decimal digits. It adds an enable with built-in prescaler, synchronous parallel load, a selectable wrap or saturate mode at the count limits, and a terminal-count pulse. Its packed BCD output feeds the seven-segment digit multiplexer directly.

## Interface
- DIGITS, 3, number of BCD digits (1..8); digit 0 is the least significant, at CNT[3:0].
- DIV, 1, prescaler ratio: one count step per DIV enabled clocks (1..2^24).
- WRAP, 1, 1 = wrap at limits; 0 = saturate at limits.
- CE  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- EN  in  1  count enable; the prescaler advances only when EN=1.
- REVERSE  in  1  direction: 0 = up, 1 = down.
- LOAD  in  1  synchronous parallel load strobe.
- LOAD_VAL  in  4*DIGITS  packed BCD value to load.
- CNT  out  4*DIGITS  packed BCD count.
- TC  out  1  one-cycle terminal-count pulse.
- LOAD_ERR  out  1  sticky flag: the last load contained a non-BCD nibble.

## Operation
- Reset (RESET=0, asynchronous) sets:
  - CNT = 0
  - TC = 0
  - LOAD_ERR = 0
  - prescaler = 0
- Priority per edge: LOAD, then count step, then hold.
- LOAD=1:
  - Each nibble of LOAD_VAL is copied into CNT. Any nibble greater than 9 is stored as 0 instead.
  - LOAD_ERR = 1 if any nibble was greater than 9, else 0.
  - The prescaler clears to 0.
  - TC = 0 on this edge, regardless of EN.
- Prescaler:
  - Width is max(1, $clog2(DIV)) bits.
  - When EN=1 and LOAD=0, it increments. When it equals DIV-1, it returns to 0 and generates a tick.
  - With DIV=1, every enabled cycle is a tick.
  - EN=0 freezes the prescaler at its current value; it does not clear.
- Tick, up direction (REVERSE=0):
  - Digit 0 increments. A digit at 9 goes to 0 and carries into the next digit.
  - At all-9s: WRAP=1 gives CNT = 0; WRAP=0 holds all-9s. In both cases TC = 1.
- Tick, down direction (REVERSE=1):
  - Digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
  - At 0: WRAP=1 gives CNT = all-9s; WRAP=0 holds 0. In both cases TC = 1.
- In saturate mode, TC pulses on every tick taken while at the limit in the current direction.
- TC is 0 on every edge without a limit tick.
- REVERSE is sampled only on tick edges. A change between ticks never alters CNT or the prescaler.
- Digits always hold values 0..9; no illegal BCD state is reachable.

## Timing
- Fully synchronous to CE; no combinational path from any input to any output.
- Latency:
  - CNT and TC update on the same rising edge as the tick or load.
  - The pulse is visible for exactly one CE cycle after that edge.
- A count step occurs on the edge of the DIV-th consecutive enabled cycle after reset or load.
- LOAD and a would-be tick on the same edge: the load wins, the tick is discarded, and the prescaler restarts.
- RESET mid-count is asynchronous; all state clears immediately. The first tick after release needs DIV enabled cycles.
- The carry chain is combinational across all digits within one cycle. The target is 100 MHz at DIGITS=8.

## Structure
- Shared package seg7_pkg holds:
  - the BCD_MAX = 4'd9 constant
  - the BCD digit width (4)
  - the direction encoding constants UP/DOWN
- Sub-module bcd_digit, one instance per digit, generated DIGITS times.
  - Inputs: step_in, dir, load, load_nib, wrap_en.
  - Outputs: digit[3:0], carry_out (ripple to next digit), at_limit (the digit is 9 going up, or 0 going down).
- The top level owns:
  - the prescaler
  - the all-digits-at-limit AND used for saturate/TC
  - the TC and LOAD_ERR registers

## Test plan
- **Reset and basic count:** DIGITS=3, DIV=1, EN=1, REVERSE=0. Release RESET and run 1000 edges → CNT steps 000, 001, … 999, then wraps to 000. TC is high only in the cycle CNT shows 000 after the wrap.
- **Down with wrap vs saturate:** LOAD 002, REVERSE=1.
  - WRAP=1 → CNT goes 001, 000, 999, with TC on 999.
  - WRAP=0 → CNT goes 001, 000, 000, with TC on every tick at 000.
- **Prescaler:** DIV=5, EN=1 → CNT increments every 5 edges. Toggle EN low for 3 cycles mid-period → the step is delayed by exactly 3 cycles.
- **Load:**
  - LOAD_VAL=0x4A7 → CNT=407, LOAD_ERR=1.
  - Then LOAD 0x123 → CNT=123, LOAD_ERR=0.
  - LOAD on the same edge as a tick → CNT equals the loaded value, and the next step comes DIV enabled cycles later.
- **Direction change:** from 500, toggle REVERSE between ticks (DIV=4) → each step follows REVERSE at the tick edge. No intermediate glitch on CNT.
- **Asynchronous reset:** assert RESET between CE edges while CNT=789 → CNT=0, TC=0 and LOAD_ERR=0 before the next CE edge.
